// File: rtl/control_unit.sv
// control_unit
//   Microcoded sequencer for a small 8-bit accumulator CPU. Every instruction
//   runs five T-states (T0..T4); the control word is a combinational decode of
//   the current T-state, the opcode, the latched ALU flags and the halt state.
//
// Ports
//   clk     in   system clock, all state changes on the rising edge
//   rst     in   asynchronous reset, active low
//   opcode  in   [3:0] instruction-register high nibble (not latched here)
//   zf      in   ALU zero flag (combinational from the ALU)
//   cf      in   ALU carry/borrow flag (combinational from the ALU)
//   ctrl    out  [15:0] control word:
//                15 hlt 14 mi 13 ri 12 ro 11 io 10 ii 9 ai 8 ao
//                 7 eo   6 su  5 bi  4 oi  3 ce  2 co 1 j  0 fi
//   step    out  [2:0] current T-state, 0..4
//   flag_z  out  latched zero flag
//   flag_c  out  latched carry flag
//   halted  out  set once HLT executes; only reset clears it
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        zf,
  input  logic        cf,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        flag_z,
  output logic        flag_c,
  output logic        halted
);

  // Control-word bit masks
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  // Opcode map; anything not listed decodes as NOP
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_t;

  tstate_t     state;
  tstate_t     state_next;
  logic [15:0] word;

  // Microcode decode. Conditional jumps look only at the latched flags.
  always_comb begin
    word = '0;
    if (halted) begin
      word = C_HLT;
    end else begin
      case (state)
        T0: word = C_CO | C_MI;
        T1: word = C_RO | C_II | C_CE;
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: word = C_IO | C_MI;
            OP_LDI: word = C_IO | C_AI;
            OP_JMP: word = C_IO | C_J;
            OP_JC:  word = flag_c ? (C_IO | C_J) : '0;
            OP_JZ:  word = flag_z ? (C_IO | C_J) : '0;
            OP_OUT: word = C_AO | C_OI;
            OP_HLT: word = C_HLT;
            default: word = '0;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA:         word = C_RO | C_AI;
            OP_ADD, OP_SUB: word = C_RO | C_BI;
            OP_STA:         word = C_AO | C_RI;
            default:        word = '0;
          endcase
        end
        T4: begin
          case (opcode)
            OP_ADD:  word = C_EO | C_AI | C_FI;
            OP_SUB:  word = C_EO | C_AI | C_FI | C_SU;
            default: word = '0;
          endcase
        end
        default: word = '0;
      endcase
    end
  end

  // Fixed five-state ring; out-of-range encodings recover to T0
  always_comb begin
    case (state)
      T0:      state_next = T1;
      T1:      state_next = T2;
      T2:      state_next = T3;
      T3:      state_next = T4;
      default: state_next = T0;
    endcase
  end

  // ctrl is forced to zero while reset is held, not just at the edge
  assign ctrl = rst ? word : '0;
  assign step = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= T0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (word[0]) begin
        flag_z <= zf;
        flag_c <= cf;
      end
      // HLT freezes the sequencer in T2
      if (state == T2 && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else begin
        state <= state_next;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        zf;
  logic        cf;
  logic [15:0] ctrl;
  logic [2:0]  step;
  logic        flag_z;
  logic        flag_c;
  logic        halted;

  control_unit dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zf     (zf),
    .cf     (cf),
    .ctrl   (ctrl),
    .step   (step),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Reference model: microcode table indexed [opcode][T-state] plus abstract state
  logic [15:0] micro [16][5];
  int          m_step;
  bit          m_fz;
  bit          m_fc;
  bit          m_halt;

  task automatic init_micro();
    for (int op = 0; op < 16; op++) begin
      micro[op][0] = 16'h4004;
      micro[op][1] = 16'h1408;
      micro[op][2] = 16'h0000;
      micro[op][3] = 16'h0000;
      micro[op][4] = 16'h0000;
    end
    micro[1][2]  = 16'h4800; micro[1][3] = 16'h1200;
    micro[2][2]  = 16'h4800; micro[2][3] = 16'h1020; micro[2][4] = 16'h0281;
    micro[3][2]  = 16'h4800; micro[3][3] = 16'h1020; micro[3][4] = 16'h02C1;
    micro[4][2]  = 16'h4800; micro[4][3] = 16'h2100;
    micro[5][2]  = 16'h0A00;
    micro[6][2]  = 16'h0802;
    micro[7][2]  = 16'h0802;
    micro[8][2]  = 16'h0802;
    micro[14][2] = 16'h0110;
    micro[15][2] = 16'h8000;
  endtask

  function automatic logic [15:0] exp_ctrl();
    if (!rst) return 16'h0000;
    if (m_halt) return 16'h8000;
    if (m_step == 2 && ((opcode == 4'd7 && !m_fc) || (opcode == 4'd8 && !m_fz)))
      return 16'h0000;
    return micro[opcode][m_step];
  endfunction

  task automatic model_reset();
    m_step = 0; m_fz = 0; m_fc = 0; m_halt = 0;
  endtask

  // Applies one rising edge to the model using the inputs seen at that edge
  task automatic model_tick();
    logic [15:0] w;
    w = exp_ctrl();
    if (!m_halt) begin
      if (w[0]) begin
        m_fz = zf;
        m_fc = cf;
      end
      if (m_step == 2 && opcode == 4'hF) m_halt = 1;
      else m_step = (m_step + 1) % 5;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic goto_step(input int s);
    for (int k = 0; k < 6 && m_step != s; k++) advance();
  endtask

  task automatic test_reset();
    rst = 1'b0; opcode = 4'h0; zf = 1'b0; cf = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (ctrl !== 16'h0000) $display("FAIL reset_ctrl got=%h exp=0000", ctrl); else n_pass++;
    n_total++;
    if (step !== 3'd0) $display("FAIL reset_step got=%0d exp=0", step); else n_pass++;
    n_total++;
    if ({flag_z, flag_c, halted} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {flag_z, flag_c, halted}); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (ctrl !== 16'h4004) $display("FAIL reset_release_t0 got=%h exp=4004", ctrl); else n_pass++;
  endtask

  task automatic test_nop_sequence();
    logic [15:0] seq [5];
    seq[0] = 16'h4004; seq[1] = 16'h1408; seq[2] = 16'h0000; seq[3] = 16'h0000; seq[4] = 16'h0000;
    opcode = 4'h0;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_total++;
      if (ctrl !== seq[c % 5])
        $display("FAIL nop_ctrl cycle=%0d got=%h exp=%h", c, ctrl, seq[c % 5]); else n_pass++;
      n_total++;
      if (step !== 3'(c % 5))
        $display("FAIL nop_step cycle=%0d got=%0d exp=%0d", c, step, c % 5); else n_pass++;
      advance();
    end
  endtask

  task automatic test_add_flags();
    goto_step(0);
    opcode = 4'b0010; zf = 1'b0; cf = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_total++;
      if (ctrl !== exp_ctrl())
        $display("FAIL add_ctrl t=%0d got=%h exp=%h", m_step, ctrl, exp_ctrl()); else n_pass++;
      if (c == 3) begin
        n_total++;
        if (ctrl !== 16'h1020) $display("FAIL add_t3 got=%h exp=1020", ctrl); else n_pass++;
      end
      if (c == 4) begin
        n_total++;
        if (ctrl !== 16'h0281) $display("FAIL add_t4 got=%h exp=0281", ctrl); else n_pass++;
      end
      advance();
    end
    #1;
    n_total++;
    if ({flag_z, flag_c} !== 2'b01)
      $display("FAIL add_flags got zf=%b cf=%b exp zf=0 cf=1", flag_z, flag_c); else n_pass++;
  endtask

  task automatic test_sub_jumps();
    goto_step(0);
    opcode = 4'b0011; zf = 1'b1; cf = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 4) begin
        n_total++;
        if (ctrl !== 16'h02C1) $display("FAIL sub_t4 got=%h exp=02C1", ctrl); else n_pass++;
      end
      advance();
    end
    // Live flags now disagree with the latched ones; jumps must ignore them
    zf = 1'b0; cf = 1'b1;
    opcode = 4'b1000;
    goto_step(2);
    #1;
    n_total++;
    if (ctrl !== 16'h0802) $display("FAIL jz_taken_t2 got=%h exp=0802", ctrl); else n_pass++;
    goto_step(0);
    opcode = 4'b0111;
    goto_step(2);
    #1;
    n_total++;
    if (ctrl !== 16'h0000) $display("FAIL jc_not_taken_t2 got=%h exp=0000", ctrl); else n_pass++;
    goto_step(0);
  endtask

  task automatic test_undefined();
    bit fz0, fc0;
    goto_step(0);
    opcode = 4'b1011;
    fz0 = m_fz; fc0 = m_fc;
    for (int c = 0; c < 5; c++) begin
      zf = 1'($urandom); cf = 1'($urandom);
      #1;
      if (c >= 2) begin
        n_total++;
        if (ctrl !== 16'h0000) $display("FAIL undef_ctrl t=%0d got=%h exp=0000", c, ctrl); else n_pass++;
      end
      advance();
    end
    #1;
    n_total++;
    if ({flag_z, flag_c} !== {fz0, fc0})
      $display("FAIL undef_flags got=%b%b exp=%b%b", flag_z, flag_c, fz0, fc0); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      if (m_step == 0 || $urandom_range(0, 7) == 0) opcode = 4'($urandom_range(0, 14));
      zf = 1'($urandom); cf = 1'($urandom);
      #1;
      n_total++;
      if (ctrl !== exp_ctrl())
        $display("FAIL rand_ctrl cyc=%0d op=%h t=%0d got=%h exp=%h", c, opcode, m_step, ctrl, exp_ctrl());
      else n_pass++;
      n_total++;
      if ({step, flag_z, flag_c, halted} !== {3'(m_step), m_fz, m_fc, m_halt})
        $display("FAIL rand_state cyc=%0d got=%0d%b%b%b exp=%0d%b%b%b", c, step, flag_z, flag_c,
                 halted, m_step, m_fz, m_fc, m_halt);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_async_reset();
    goto_step(0);
    opcode = 4'b0010; zf = 1'b1; cf = 1'b1;
    repeat (5) advance();
    goto_step(3);
    #1;
    n_total++;
    if ({flag_z, flag_c} !== 2'b11 || ctrl !== 16'h1020)
      $display("FAIL areset_pre got flags=%b%b ctrl=%h exp flags=11 ctrl=1020", flag_z, flag_c, ctrl);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({ctrl, step, flag_z, flag_c, halted} !== {16'h0000, 3'd0, 3'b000})
      $display("FAIL areset_during got ctrl=%h step=%0d flags=%b%b%b exp 0000/0/000",
               ctrl, step, flag_z, flag_c, halted);
    else n_pass++;
    model_reset();
    rst = 1'b1;
    #1;
    n_total++;
    if (ctrl !== 16'h4004) $display("FAIL areset_release got=%h exp=4004", ctrl); else n_pass++;
    advance();
    #1;
    n_total++;
    if (ctrl !== 16'h1408 || step !== 3'd1)
      $display("FAIL areset_next got ctrl=%h step=%0d exp 1408/1", ctrl, step); else n_pass++;
  endtask

  task automatic test_halt();
    bit fz0, fc0;
    goto_step(0);
    opcode = 4'hF;
    goto_step(2);
    #1;
    n_total++;
    if (ctrl !== 16'h8000 || halted !== 1'b0)
      $display("FAIL halt_t2 got ctrl=%h halted=%b exp 8000/0", ctrl, halted); else n_pass++;
    fz0 = m_fz; fc0 = m_fc;
    advance();
    #1;
    n_total++;
    if (halted !== 1'b1 || step !== 3'd2)
      $display("FAIL halt_set got halted=%b step=%0d exp 1/2", halted, step); else n_pass++;
    for (int c = 0; c < 12; c++) begin
      opcode = 4'($urandom); zf = 1'($urandom); cf = 1'($urandom);
      #1;
      n_total++;
      if ({ctrl, step, flag_z, flag_c, halted} !== {16'h8000, 3'd2, fz0, fc0, 1'b1})
        $display("FAIL halt_hold cyc=%0d got ctrl=%h step=%0d flags=%b%b halted=%b exp 8000/2/%b%b/1",
                 c, ctrl, step, flag_z, flag_c, halted, fz0, fc0);
      else n_pass++;
      advance();
    end
    rst = 1'b0;
    #1;
    n_total++;
    if ({ctrl, step, halted} !== {16'h0000, 3'd0, 1'b0})
      $display("FAIL halt_reset got ctrl=%h step=%0d halted=%b exp 0000/0/0", ctrl, step, halted);
    else n_pass++;
    model_reset();
    rst = 1'b1;
    opcode = 4'h0;
    #1;
    n_total++;
    if (ctrl !== 16'h4004) $display("FAIL halt_release got=%h exp=4004", ctrl); else n_pass++;
    advance();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    init_micro();
    test_reset();
    advance();
    // advance() above already stepped past T0; realign the NOP walk to T0
    goto_step(0);
    test_nop_sequence();
    test_add_flags();
    test_sub_jumps();
    test_undefined();
    test_random();
    test_async_reset();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
